// File: rtl/reg_pipe_chain.sv
// Elastic register chain: DEPTH stages with per-stage valid bits, bubble collapsing and an
// occupancy count; PIPELINE=0 turns the block into a stateless combinational pass-through.
module reg_pipe_chain #(
    parameter int N        = 18,
    parameter int DEPTH    = 2,
    parameter int PIPELINE = 1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         CE,
    input  logic                         CLR,
    input  logic [N-1:0]                 D,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic [N-1:0]                 Q,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [$clog2(DEPTH+1)-1:0]   OCC
);
    localparam int OW = $clog2(DEPTH+1);

    // Handshake: a word moves across a boundary on a rising edge where valid and ready are both
    // high; valid never waits on ready, ready may depend on the downstream ready (combinational).
    if (PIPELINE != 0) begin : g_pipe
        logic [DEPTH-1:0] valid_q, valid_d;
        logic [N-1:0]     data_q [DEPTH];
        logic [N-1:0]     data_d [DEPTH];
        logic [OW-1:0]    occ_q, occ_d;
        logic [DEPTH-1:0] rdy;
        logic             out_valid, out_xfer, in_ready, in_xfer;

        // rdy[i]: stage i can take a word this edge (it is empty, or its word moves on).
        always_comb begin
            logic r;
            out_valid = CE && valid_q[DEPTH-1];
            out_xfer  = out_valid && OUT_READY;
            r         = !valid_q[DEPTH-1] || out_xfer;
            rdy       = '0;
            rdy[DEPTH-1] = r;
            for (int i = DEPTH - 2; i >= 0; i--) begin
                r      = !valid_q[i] || r;
                rdy[i] = r;
            end
            in_ready = RST_N && CE && !CLR && rdy[0];
            in_xfer  = IN_VALID && in_ready;
        end

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            occ_d   = occ_q;
            if (CLR) begin
                valid_d = '0;
                for (int i = 0; i < DEPTH; i++) data_d[i] = '0;
                occ_d = '0;
            end else if (CE) begin
                if (rdy[0]) begin
                    valid_d[0] = in_xfer;
                    if (in_xfer) data_d[0] = D;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (rdy[i]) begin
                        valid_d[i] = valid_q[i-1];
                        if (valid_q[i-1]) data_d[i] = data_q[i-1];
                    end
                end
                occ_d = occ_q + OW'(in_xfer) - OW'(out_xfer);
            end
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                valid_q <= '0;
                for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
                occ_q <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                occ_q   <= occ_d;
            end
        end

        assign IN_READY  = in_ready;
        assign OUT_VALID = out_valid;
        assign Q         = out_valid ? data_q[DEPTH-1] : '0;
        assign OCC       = occ_q;
    end else begin : g_bypass
        assign OUT_VALID = RST_N && CE && !CLR && IN_VALID;
        assign IN_READY  = RST_N && CE && !CLR && OUT_READY;
        assign Q         = OUT_VALID ? D : '0;
        assign OCC       = '0;
    end

endmodule
